// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared sizing constants and peak-detector state encoding for
//               the FFT output-side blocks (buffers and peak detector).
// Contents    : DATA_W, NUM_BINS, IDX_W, MAG_W, SKIP_DC, peak_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int DATA_W   = 16;            // width of each re / im half
    localparam int NUM_BINS = 32;            // bins per FFT frame
    localparam int IDX_W    = 5;             // $clog2(NUM_BINS)
    localparam int MAG_W    = 2 * DATA_W + 1; // re^2 + im^2 without overflow
    localparam int SKIP_DC  = 1;             // exclude bin 0 from the peak search

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } peak_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_bin_power.sv
`default_nettype none
// ============================================================================
// Module      : fft_bin_power
// Description : Registered squarer, first pipeline stage of the peak detector.
//               Squares the signed re and im halves of an accepted bin and
//               carries the bin index alongside.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               flush          - drop any bin entering this cycle
//               in_valid/re/im/in_idx   - bin being accepted
//               out_valid/re2/im2/out_idx - squared bin, one cycle later
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bin_power
    import fft_pkg::*;
#(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int IDX_W  = fft_pkg::IDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     re,
    input  logic [DATA_W-1:0]     im,
    input  logic [IDX_W-1:0]      in_idx,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   re2,
    output logic [2*DATA_W-1:0]   im2,
    output logic [IDX_W-1:0]      out_idx
);

    logic                valid_q, valid_d;
    logic [2*DATA_W-1:0] re2_q, re2_d;
    logic [2*DATA_W-1:0] im2_q, im2_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // A signed square is never negative and at most 2^(2*DATA_W-2), so the
    // 2*DATA_W-bit product can be carried on as an unsigned value.
    always_comb begin
        valid_d = in_valid & ~flush;
        re2_d   = re2_q;
        im2_d   = im2_q;
        idx_d   = idx_q;
        if (in_valid && !flush) begin
            re2_d = $signed(re) * $signed(re);
            im2_d = $signed(im) * $signed(im);
            idx_d = in_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            re2_q   <= '0;
            im2_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            re2_q   <= re2_d;
            im2_q   <= im2_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign re2       = re2_q;
    assign im2       = im2_q;
    assign out_idx   = idx_q;

endmodule
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_detect
// Description : Watches the {re,im} FFT result stream and reports the bin
//               with the largest power re^2+im^2 of each frame through a
//               valid/ack handshake.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               fft_start             - new frame begins
//               fft_done, fft_out32   - bin strobe and {re,im} data
//               peak_ack              - consumer took the result
//               peak_valid/idx/mag    - result, held until acked
//               frame_err             - sticky: frame restarted mid-stream
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DATA_W   = fft_pkg::DATA_W,
    parameter int NUM_BINS = fft_pkg::NUM_BINS,
    parameter int IDX_W    = fft_pkg::IDX_W,
    parameter int SKIP_DC  = fft_pkg::SKIP_DC,
    parameter int MAG_W    = fft_pkg::MAG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fft_start,
    input  logic                fft_done,
    input  logic [2*DATA_W-1:0] fft_out32,
    input  logic                peak_ack,
    output logic                peak_valid,
    output logic [IDX_W-1:0]    peak_idx,
    output logic [MAG_W-1:0]    peak_mag,
    output logic                frame_err
);

    // Counter holds 0..NUM_BINS, hence one bit wider than the index.
    localparam int                C_CNT_W     = IDX_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(NUM_BINS);
    localparam logic [IDX_W-1:0]  C_FIRST_IDX = (SKIP_DC != 0) ? IDX_W'(1) : IDX_W'(0);

    peak_state_t          state_q, state_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [MAG_W-1:0]     best_mag_q, best_mag_d;
    logic [IDX_W-1:0]     peak_idx_q, peak_idx_d;
    logic [MAG_W-1:0]     peak_mag_q, peak_mag_d;
    logic                 frame_err_q, frame_err_d;

    logic                 accept;
    logic                 s1_valid;
    logic [2*DATA_W-1:0]  s1_re2;
    logic [2*DATA_W-1:0]  s1_im2;
    logic [IDX_W-1:0]     s1_idx;
    logic [MAG_W-1:0]     s1_mag;
    logic                 s1_cand;

    // Stage 1: square the accepted bin. A start always wins over fft_done and
    // discards whatever would enter the pipeline on that edge.
    fft_bin_power #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bin_power (
        .clk       (clk),
        .reset     (reset),
        .flush     (fft_start),
        .in_valid  (accept),
        .re        (fft_out32[2*DATA_W-1:DATA_W]),
        .im        (fft_out32[DATA_W-1:0]),
        .in_idx    (count_q[IDX_W-1:0]),
        .out_valid (s1_valid),
        .re2       (s1_re2),
        .im2       (s1_im2),
        .out_idx   (s1_idx)
    );

    // Stage 2 operands. DC is counted but never allowed to become the peak.
    assign s1_mag  = MAG_W'(s1_re2) + MAG_W'(s1_im2);
    assign s1_cand = s1_valid && !((SKIP_DC != 0) && (s1_idx == '0));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        best_idx_d  = best_idx_q;
        best_mag_d  = best_mag_q;
        peak_idx_d  = peak_idx_q;
        peak_mag_d  = peak_mag_q;
        frame_err_d = frame_err_q;
        accept      = 1'b0;

        // Strict compare: an equal power later in the frame keeps the
        // earlier (lower) index.
        if (s1_cand && (s1_mag > best_mag_q)) begin
            best_mag_d = s1_mag;
            best_idx_d = s1_idx;
        end

        if (fft_start) begin
            // Restart from any state; overrides the stage-2 update above so
            // the in-flight bin of an abandoned frame cannot leak through.
            if (((state_q == SCAN) && (count_q != '0) && (count_q < C_FULL)) ||
                (state_q == DRAIN)) begin
                frame_err_d = 1'b1;
            end
            state_d    = SCAN;
            count_d    = '0;
            best_mag_d = '0;
            best_idx_d = C_FIRST_IDX;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SCAN: begin
                    if (count_q == C_FULL) begin
                        // Last bin is in stage 2 this cycle.
                        state_d = DRAIN;
                    end else if (fft_done) begin
                        accept  = 1'b1;
                        count_d = count_q + C_CNT_W'(1);
                    end
                end
                DRAIN: begin
                    state_d    = HOLD;
                    peak_idx_d = best_idx_q;
                    peak_mag_d = best_mag_q;
                end
                HOLD: begin
                    if (peak_ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            peak_idx_q  <= '0;
            peak_mag_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            best_idx_q  <= best_idx_d;
            best_mag_q  <= best_mag_d;
            peak_idx_q  <= peak_idx_d;
            peak_mag_q  <= peak_mag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign peak_valid = (state_q == HOLD);
    assign peak_idx   = peak_idx_q;
    assign peak_mag   = peak_mag_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
